// File: rtl/io_devices.sv
// Memory-mapped I/O device bank: read-only id word at 0, R/W latches above.
// Define IODEVICES_WRITE_COUNT_EN to expose an accepted-write counter at id 8'hFF.
module io_devices #(
  parameter int NUM_DEVICES = 8,
  parameter int DATA_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            device_id,
  input  logic [DATA_WIDTH-1:0] value_in,
  input  logic                  is_write,
  output logic [DATA_WIDTH-1:0] value_out
);

  localparam logic [7:0] NUM_ID = 8'(NUM_DEVICES);
  localparam logic [DATA_WIDTH-1:0] ID_WORD =
    {16'h494F, 8'h00, NUM_ID};

  logic [DATA_WIDTH-1:0] regs [1:NUM_DEVICES-1];
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  hit;

  assign hit = (device_id != 8'h00) && (device_id < NUM_ID);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 1; i < NUM_DEVICES; i++)
        regs[i] <= '0;
    end else if (is_write) begin
      for (int i = 1; i < NUM_DEVICES; i++)
        if (device_id == 8'(i))
          regs[i] <= value_in;
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 1; i < NUM_DEVICES; i++)
      if (device_id == 8'(i))
        rd_data = regs[i];
  end

`ifdef IODEVICES_WRITE_COUNT_EN
  logic [31:0] wr_count;

  // Reset drops a simultaneous write, so it is never counted.
  always_ff @(posedge clk) begin
    if (reset)
      wr_count <= '0;
    else if (is_write && hit)
      wr_count <= wr_count + 32'd1;
  end
`endif

  always_comb begin
    value_out = '0;
    unique case (1'b1)
      (device_id == 8'h00): value_out = ID_WORD;
      hit:                  value_out = rd_data;
`ifdef IODEVICES_WRITE_COUNT_EN
      (device_id == 8'hFF): value_out = wr_count;
`endif
      default:              value_out = '0;
    endcase
  end

endmodule

// File: tb/tb_io_devices.sv
// Directed-vector bench for io_devices.
// Expected values are hand-computed constants.
module tb_io_devices;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  device_id;
  logic [31:0] value_in;
  logic        is_write;
  logic [31:0] value_out;

  int n_vec = 0;
  int n_err = 0;

  io_devices #(.NUM_DEVICES(8), .DATA_WIDTH(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .device_id(device_id),
    .value_in (value_in),
    .is_write (is_write),
    .value_out(value_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input string tag,
                    input logic [7:0] id,
                    input logic [31:0] exp);
    device_id = id;
    #1;
    check(tag, value_out, exp);
  endtask

  task automatic wr(input logic [7:0] id, input logic [31:0] v);
    device_id = id;
    value_in  = v;
    is_write  = 1'b1;
    tick();
    is_write  = 1'b0;
  endtask

  logic [31:0] exp_ff;

  initial begin
    reset     = 1'b1;
    device_id = 8'h00;
    value_in  = '0;
    is_write  = 1'b0;
    tick();
    reset = 1'b0;

    rd("rst_id0", 8'd0, 32'h494F0008);
    for (int i = 1; i < 10; i++)
      rd($sformatf("rst_id%0d", i), 8'(i), 32'h0);
    rd("rst_idFF", 8'hFF, 32'h0);

    wr(8'd1, 32'hE5F84AB1);
    rd("wr1_id0", 8'd0, 32'h494F0008);
    rd("wr1_id1", 8'd1, 32'hE5F84AB1);

    wr(8'd7, 32'h5C8C6A01);
    wr(8'd0, 32'h12345678);
    wr(8'd9, 32'h0BADF00D);
    wr(8'hFF, 32'h0BADF00D);
    rd("wr_id7", 8'd7, 32'h5C8C6A01);
    rd("wr_id0", 8'd0, 32'h494F0008);
    rd("wr_id9", 8'd9, 32'h0);
    rd("wr_id1_kept", 8'd1, 32'hE5F84AB1);

    device_id = 8'd2;
    value_in  = 32'hAAAA5555;
    is_write  = 1'b1;
    reset     = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("rst_pri_id2", value_out, 32'h0);
    tick();
    is_write = 1'b0;
    check("rst_after_id2", value_out, 32'hAAAA5555);
    rd("rst_pri_id1", 8'd1, 32'h0);

    device_id = 8'd3;
    value_in  = 32'hDEADBEEF;
    is_write  = 1'b1;
    #1;
    check("same_old", value_out, 32'h0);
    tick();
    check("same_new", value_out, 32'hDEADBEEF);
    is_write = 1'b0;
    value_in = 32'h01234567;
    tick();
    tick();
    check("hold_id3", value_out, 32'hDEADBEEF);

    device_id = 8'd4;
    is_write  = 1'b1;
    value_in  = 32'h11111111;
    tick();
    value_in  = 32'h22222222;
    tick();
    is_write = 1'b0;
    check("rewrite_id4", value_out, 32'h22222222);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    wr(8'd1, 32'h1);
    wr(8'd5, 32'h5);
    wr(8'd7, 32'h7);
    wr(8'd0, 32'hFFFFFFFF);
`ifdef IODEVICES_WRITE_COUNT_EN
    exp_ff = 32'h3;
`else
    exp_ff = 32'h0;
`endif
    rd("cnt_idFF", 8'hFF, exp_ff);
    rd("cnt_id5", 8'd5, 32'h5);
    rd("cnt_id3_clr", 8'd3, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
